// File: rtl/fmc_pkg.sv
// Shared types and bus-level constants for the FMC master.
// The state enum is also the type of the debug state output.
package fmc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LAT,
      ST_DATA,
      ST_END
   } fmc_state_t;

   // Active-low strobes: level driven while the bus is released.
   localparam logic FMC_CTRL_IDLE = 1'b1;
   localparam logic FMC_CTRL_ACT  = 1'b0;

   // FMC_D_T polarity: 1 releases the pad, 0 drives FMC_D_O.
   localparam logic FMC_TRI_HIZ = 1'b1;
   localparam logic FMC_TRI_DRV = 1'b0;

endpackage

// File: rtl/fmc_mst_clkgen.sv
// Free-running FMC_CLK divider.
// Ticks are high in the clk cycle whose closing edge moves FMC_CLK.
module fmc_mst_clkgen #(
   parameter int C_CLK_DIV = 1
) (
   input  logic clk,
   input  logic rst_n,
   output logic fmc_clk,
   output logic fall_tick,
   output logic rise_tick
);

   logic [3:0] div_cnt;
   logic       wrap;

   assign wrap      = (div_cnt == 4'(C_CLK_DIV - 1));
   assign rise_tick = wrap & ~fmc_clk;
   assign fall_tick = wrap & fmc_clk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         fmc_clk <= 1'b0;
      end else if (wrap) begin
         div_cnt <= '0;
         fmc_clk <= ~fmc_clk;
      end else begin
         div_cnt <= div_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/fmc_mst_if.sv
// Synchronous PSRAM-mode FMC master: one single-beat access per request.
// Bus outputs move on fall_tick only; FMC_D_I and FMC_NWAIT are sampled on rise_tick.
module fmc_mst_if
   import fmc_pkg::*;
#(
   parameter int C_ADDR_WIDTH   = 12,
   parameter int C_DATA_WIDTH   = 16,
   parameter int C_CLK_DIV      = 1,
   parameter int C_DATLAT       = 2,
   parameter int C_WAIT_TIMEOUT = 64
) (
   input  logic                      clk,
   input  logic                      rst_n,
   // Request port: a request is taken on a clk edge where req_valid and req_ready are both 1.
   // Response port: rsp_valid is a one-clk pulse with no back-pressure.
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [C_ADDR_WIDTH-1:0]   req_addr,
   input  logic [C_DATA_WIDTH-1:0]   req_wdata,
   input  logic [C_DATA_WIDTH/8-1:0] req_be,
   output logic                      rsp_valid,
   output logic [C_DATA_WIDTH-1:0]   rsp_rdata,
   output logic                      rsp_err,
   output logic                      FMC_CLK,
   output logic [C_ADDR_WIDTH-1:0]   FMC_A,
   input  logic [C_DATA_WIDTH-1:0]   FMC_D_I,
   output logic [C_DATA_WIDTH-1:0]   FMC_D_O,
   output logic [C_DATA_WIDTH-1:0]   FMC_D_T,
   output logic [C_DATA_WIDTH/8-1:0] FMC_NBL,
   output logic                      FMC_NE,
   output logic                      FMC_NL,
   output logic                      FMC_NOE,
   output logic                      FMC_NWE,
   input  logic                      FMC_NWAIT,
   output fmc_state_t                dbg_state
);

   localparam int BW  = C_DATA_WIDTH / 8;
   localparam int WCW = $clog2(C_WAIT_TIMEOUT + 1);

   logic                    fall_tick, rise_tick, accept;
   fmc_state_t              state_q, state_nxt;
   logic                    pend_q, write_q, done_q, tmo_q;
   logic [C_ADDR_WIDTH-1:0] addr_q;
   logic [C_DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic [BW-1:0]           be_q;
   logic [3:0]              lat_cnt_q;
   logic [WCW-1:0]          wcnt_q;

   logic                    ne_d, nl_d, noe_d, nwe_d;
   logic [BW-1:0]           nbl_d;
   logic [C_DATA_WIDTH-1:0] dt_d, do_d;

   fmc_mst_clkgen #(.C_CLK_DIV(C_CLK_DIV)) u_clkgen (
      .clk       (clk),
      .rst_n     (rst_n),
      .fmc_clk   (FMC_CLK),
      .fall_tick (fall_tick),
      .rise_tick (rise_tick)
   );

   assign accept    = req_valid & req_ready;
   assign dbg_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      if (fall_tick) begin
         case (state_q)
            ST_IDLE: if (pend_q) state_nxt = ST_ADDR;
            ST_ADDR: state_nxt = (C_DATLAT > 0) ? ST_LAT : ST_DATA;
            ST_LAT:  if (lat_cnt_q == 4'(C_DATLAT - 1)) state_nxt = ST_DATA;
            ST_DATA: if (done_q || tmo_q) state_nxt = ST_END;
            ST_END:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Bus levels for the FMC cycle being entered; registered on fall_tick.
   always_comb begin
      ne_d  = FMC_CTRL_IDLE;
      nl_d  = FMC_CTRL_IDLE;
      noe_d = FMC_CTRL_IDLE;
      nwe_d = FMC_CTRL_IDLE;
      nbl_d = '1;
      dt_d  = {C_DATA_WIDTH{FMC_TRI_HIZ}};
      do_d  = '0;
      case (state_nxt)
         ST_ADDR, ST_LAT, ST_DATA: begin
            ne_d  = FMC_CTRL_ACT;
            nwe_d = write_q ? FMC_CTRL_ACT : FMC_CTRL_IDLE;
            nbl_d = ~be_q;
            if (state_nxt == ST_ADDR) nl_d = FMC_CTRL_ACT;
            if (state_nxt == ST_DATA) begin
               if (write_q) begin
                  dt_d = {C_DATA_WIDTH{FMC_TRI_DRV}};
                  do_d = wdata_q;
               end else begin
                  noe_d = FMC_CTRL_ACT;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         FMC_NE  <= FMC_CTRL_IDLE;
         FMC_NL  <= FMC_CTRL_IDLE;
         FMC_NOE <= FMC_CTRL_IDLE;
         FMC_NWE <= FMC_CTRL_IDLE;
         FMC_NBL <= '1;
         FMC_D_T <= {C_DATA_WIDTH{FMC_TRI_HIZ}};
         FMC_D_O <= '0;
         FMC_A   <= '0;
      end else if (fall_tick) begin
         FMC_NE  <= ne_d;
         FMC_NL  <= nl_d;
         FMC_NOE <= noe_d;
         FMC_NWE <= nwe_d;
         FMC_NBL <= nbl_d;
         FMC_D_T <= dt_d;
         FMC_D_O <= do_d;
         if (state_nxt == ST_ADDR) FMC_A <= addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         pend_q    <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         lat_cnt_q <= '0;
         wcnt_q    <= '0;
         done_q    <= 1'b0;
         tmo_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         // Ready trails the return to IDLE by one clk and drops on the accepting edge.
         req_ready <= (state_q == ST_IDLE) && !pend_q && !accept;
         rsp_valid <= 1'b0;

         if (accept) begin
            pend_q  <= 1'b1;
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
         end else if (fall_tick && state_q == ST_IDLE) begin
            pend_q <= 1'b0;
         end

         if (fall_tick) lat_cnt_q <= (state_q == ST_LAT) ? lat_cnt_q + 4'd1 : 4'd0;

         // NWAIT only matters in DATA; each low sample is one wait cycle.
         if (state_q != ST_DATA) begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            wcnt_q <= '0;
         end else if (rise_tick && !done_q && !tmo_q) begin
            if (FMC_NWAIT) begin
               done_q  <= 1'b1;
               rdata_q <= FMC_D_I;
            end else begin
               wcnt_q <= wcnt_q + 1'b1;
               if (wcnt_q == WCW'(C_WAIT_TIMEOUT - 1)) tmo_q <= 1'b1;
            end
         end

         if (fall_tick && state_q == ST_DATA && state_nxt == ST_END) begin
            rsp_valid <= 1'b1;
            rsp_err   <= tmo_q;
            rsp_rdata <= (write_q || tmo_q) ? '0 : rdata_q;
         end
      end
   end

endmodule

// File: tb/tb_fmc_mst_if.sv
// Self-checking bench for fmc_mst_if with a behavioural PSRAM slave and a
// per-FMC-cycle bus recorder.
module tb_fmc_mst_if;
   import fmc_pkg::*;

   localparam int AW = 12;
   localparam int DW = 16;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic [BW-1:0] req_be;
   logic          rsp_valid, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic          FMC_CLK, FMC_NE, FMC_NL, FMC_NOE, FMC_NWE, FMC_NWAIT;
   logic [AW-1:0] FMC_A;
   logic [DW-1:0] FMC_D_I, FMC_D_O, FMC_D_T;
   logic [BW-1:0] FMC_NBL;
   fmc_state_t    dbg_state;

   fmc_mst_if dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .FMC_CLK(FMC_CLK), .FMC_A(FMC_A), .FMC_D_I(FMC_D_I), .FMC_D_O(FMC_D_O),
      .FMC_D_T(FMC_D_T), .FMC_NBL(FMC_NBL), .FMC_NE(FMC_NE), .FMC_NL(FMC_NL),
      .FMC_NOE(FMC_NOE), .FMC_NWE(FMC_NWE), .FMC_NWAIT(FMC_NWAIT),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [DW:0] exp_q[$];   // {err, rdata}

   // ---------------- bus recorder: one snapshot per FMC cycle (high phase)
   typedef struct packed {
      logic          ne, nl, noe, nwe;
      logic [BW-1:0] nbl;
      logic [AW-1:0] a;
      logic [DW-1:0] d_o, d_t;
   } snap_t;
   snap_t snap [0:255];
   int   rec_n = 0;
   logic rec_on = 1'b0, rec_on_d = 1'b0, prev_fclk = 1'b0;

   always @(negedge clk) begin
      if (rec_on && !rec_on_d) rec_n = 0;
      if (rec_on && FMC_CLK && !prev_fclk && rec_n < 256) begin
         snap[rec_n] = {FMC_NE, FMC_NL, FMC_NOE, FMC_NWE, FMC_NBL, FMC_A, FMC_D_O, FMC_D_T};
         rec_n++;
      end
      rec_on_d  = rec_on;
      prev_fclk = FMC_CLK;
   end

   // ---------------- slave: drives data and NWAIT in the low phase of DATA cycles
   logic [DW-1:0] slave_rdata = '0;
   int   wait_cfg = 0, wait_used = 0;
   logic idle_nwait = 1'b1;

   always @(negedge clk) begin
      if (FMC_NE) wait_used = 0;
      if (!FMC_CLK && !FMC_NE && (!FMC_NOE || FMC_D_T == '0)) begin
         if (wait_used < wait_cfg) begin
            FMC_NWAIT = 1'b0;
            FMC_D_I   = ~slave_rdata;
            wait_used++;
         end else begin
            FMC_NWAIT = 1'b1;
            FMC_D_I   = slave_rdata;
         end
      end else begin
         FMC_NWAIT = idle_nwait;
         FMC_D_I   = 16'hDEAD;
      end
   end

   // ---------------- driver tasks (called at a negedge)
   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (req_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [BW-1:0] be, output bit ok);
      wait_ready(ok);
      if (!ok) return;
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_be = be;
      @(negedge clk);
      req_valid = 1'b0; req_wdata = $urandom_range(0, 16'hFFFF);
   endtask

   task automatic wait_rsp(input int budget, output bit ok, output logic [DW:0] got);
      ok = 1'b0; got = '0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1'b1; got = {rsp_err, rsp_rdata}; break; end
      end
   endtask

   task automatic rec_start();
      rec_on = 1'b0; repeat (2) @(negedge clk);
      rec_on = 1'b1; @(negedge clk);
   endtask

   task automatic rec_stop();
      repeat (4) @(negedge clk);
      rec_on = 1'b0;
   endtask

   // ---------------- tests
   task automatic test_reset();
      bit ok;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({FMC_CLK, FMC_NE, FMC_NL, FMC_NOE, FMC_NWE, FMC_NBL} !== 7'b0111111) begin failures++;
         $display("FAIL reset_ctrl: got %b exp 0111111", {FMC_CLK, FMC_NE, FMC_NL, FMC_NOE, FMC_NWE, FMC_NBL}); end
      checks++; if (FMC_D_T !== 16'hFFFF) begin failures++; $display("FAIL reset_dt: got %h exp ffff", FMC_D_T); end
      checks++; if ({FMC_D_O, FMC_A} !== 28'h0) begin failures++; $display("FAIL reset_do_a: got %h exp 0", {FMC_D_O, FMC_A}); end
      checks++; if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 19'h0) begin failures++;
         $display("FAIL reset_port: got %h exp 0", {req_ready, rsp_valid, rsp_err, rsp_rdata}); end
      checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE); end
      rst_n = 1'b1;
      wait_ready(ok);
      checks++; if (!ok) begin failures++; $display("FAIL reset_ready: got 0 exp 1"); end
   endtask

   task automatic test_write();
      bit ok; logic [DW:0] got, exp;
      int nl_cnt = 0, ai = 0, dat_cnt = 0, di = 0, noe_cnt = 0;
      rec_start();
      exp_q.push_back({1'b0, 16'h0000});
      send(1'b1, 12'h123, 16'hBEEF, 2'b11, ok);
      wait_rsp(100, ok, got);
      checks++;
      if (!ok) begin failures++; $display("FAIL wr_rsp: got none exp %h", exp_q[0]); end
      else begin exp = exp_q.pop_front(); if (got !== exp) begin failures++; $display("FAIL wr_rsp: got %h exp %h", got, exp); end end
      rec_stop();
      for (int i = 0; i < rec_n; i++) begin
         if (!snap[i].nl) begin nl_cnt++; ai = i; end
         if (snap[i].d_t == '0) begin dat_cnt++; di = i; end
         if (!snap[i].noe) noe_cnt++;
      end
      checks++; if (nl_cnt != 1) begin failures++; $display("FAIL wr_nl_cycles: got %0d exp 1", nl_cnt); end
      checks++; if ({snap[ai].a, snap[ai].nbl, snap[ai].ne} !== {12'h123, 2'b00, 1'b0}) begin failures++;
         $display("FAIL wr_addr_phase: got %h exp %h", {snap[ai].a, snap[ai].nbl, snap[ai].ne}, {12'h123, 2'b00, 1'b0}); end
      checks++; if (dat_cnt != 1) begin failures++; $display("FAIL wr_data_cycles: got %0d exp 1", dat_cnt); end
      checks++; if ({snap[di].d_o, snap[di].nwe} !== {16'hBEEF, 1'b0}) begin failures++;
         $display("FAIL wr_data_phase: got %h exp %h", {snap[di].d_o, snap[di].nwe}, {16'hBEEF, 1'b0}); end
      checks++; if (noe_cnt != 0) begin failures++; $display("FAIL wr_noe: got %0d exp 0", noe_cnt); end
   endtask

   task automatic test_read(input int waits, input logic [DW-1:0] data, input string tag);
      bit ok; logic [DW:0] got, exp;
      int ne_cnt = 0, noe_cnt = 0, last_ne = 0, noe_i = 0;
      idle_nwait = 1'b0;   // NWAIT low outside DATA must not stretch the access
      wait_cfg = waits; slave_rdata = data;
      rec_start();
      exp_q.push_back({1'b0, data});
      send(1'b0, AW'($urandom_range(0, 4095)), 16'h0, 2'b11, ok);
      wait_rsp(200, ok, got);
      checks++;
      if (!ok) begin failures++; $display("FAIL %s_rsp: got none exp %h", tag, exp_q[0]); end
      else begin exp = exp_q.pop_front(); if (got !== exp) begin failures++; $display("FAIL %s_rsp: got %h exp %h", tag, got, exp); end end
      rec_stop();
      idle_nwait = 1'b1;
      for (int i = 0; i < rec_n; i++) begin
         if (!snap[i].ne) begin ne_cnt++; last_ne = i; end
         if (!snap[i].noe) begin noe_cnt++; noe_i = i; end
      end
      checks++; if (noe_cnt != waits + 1) begin failures++; $display("FAIL %s_data_cycles: got %0d exp %0d", tag, noe_cnt, waits + 1); end
      checks++; if (ne_cnt != waits + 4) begin failures++; $display("FAIL %s_busy_cycles: got %0d exp %0d", tag, ne_cnt, waits + 4); end
      checks++; if (noe_i != last_ne || snap[last_ne + 1].ne !== 1'b1) begin failures++;
         $display("FAIL %s_noe_place: got noe_at=%0d end_ne=%b exp noe_at=%0d end_ne=1", tag, noe_i, snap[last_ne + 1].ne, last_ne); end
   endtask

   task automatic test_timeout();
      bit ok; logic [DW:0] got, exp;
      int noe_cnt = 0, li = 0;
      wait_cfg = 1000; slave_rdata = 16'hFFFF;
      rec_start();
      exp_q.push_back({1'b1, 16'h0000});
      send(1'b0, 12'h777, 16'h0, 2'b11, ok);
      wait_rsp(400, ok, got);
      checks++;
      if (!ok) begin failures++; $display("FAIL tmo_rsp: got none exp %h", exp_q[0]); end
      else begin exp = exp_q.pop_front(); if (got !== exp) begin failures++; $display("FAIL tmo_rsp: got %h exp %h", got, exp); end end
      rec_stop();
      wait_cfg = 0;
      for (int i = 0; i < rec_n; i++) if (!snap[i].noe) begin noe_cnt++; li = i; end
      checks++; if (noe_cnt != 64) begin failures++; $display("FAIL tmo_wait_cycles: got %0d exp 64", noe_cnt); end
      checks++; if ({snap[li + 1].ne, snap[li + 1].noe, snap[li + 1].d_t} !== {2'b11, 16'hFFFF}) begin failures++;
         $display("FAIL tmo_end_release: got %h exp %h", {snap[li + 1].ne, snap[li + 1].noe, snap[li + 1].d_t}, {2'b11, 16'hFFFF}); end
   endtask

   task automatic test_zero_be();
      bit ok; logic [DW:0] got, exp;
      int dat_cnt = 0, ai = 0;
      rec_start();
      exp_q.push_back({1'b0, 16'h0000});
      send(1'b1, 12'h3FF, 16'h5555, 2'b00, ok);
      wait_rsp(100, ok, got);
      checks++;
      if (!ok) begin failures++; $display("FAIL be0_rsp: got none exp %h", exp_q[0]); end
      else begin exp = exp_q.pop_front(); if (got !== exp) begin failures++; $display("FAIL be0_rsp: got %h exp %h", got, exp); end end
      rec_stop();
      for (int i = 0; i < rec_n; i++) begin
         if (!snap[i].nl) ai = i;
         if (snap[i].d_t == '0) dat_cnt++;
      end
      checks++; if ({snap[ai].nbl, dat_cnt[3:0]} !== {2'b11, 4'd1}) begin failures++;
         $display("FAIL be0_cycle: got nbl=%b data_cycles=%0d exp nbl=11 data_cycles=1", snap[ai].nbl, dat_cnt); end
   endtask

   task automatic test_back_to_back();
      bit ok, got1 = 1'b0, seen = 1'b0, gap_idle = 1'b0;
      logic [DW:0] g1 = '0, got, exp;
      int viol = 0, nl_cnt = 0, a1 = 0, a2 = 0;
      slave_rdata = 16'h7E81;
      rec_start();
      exp_q.push_back({1'b0, 16'h0000});
      exp_q.push_back({1'b0, 16'h7E81});
      wait_ready(ok);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h0AA; req_wdata = 16'h1234; req_be = 2'b10;
      @(negedge clk);
      req_write = 1'b0; req_addr = 12'h0BB; req_wdata = 16'h0; req_be = 2'b11;
      for (int i = 0; i < 300; i++) begin
         if (rsp_valid && !got1) begin got1 = 1'b1; g1 = {rsp_err, rsp_rdata}; end
         if (req_ready) begin if (!got1) viol++; seen = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (!got1) begin failures++; $display("FAIL b2b_rsp1: got none exp %h", exp_q[0]); end
      else begin exp = exp_q.pop_front(); if (g1 !== exp) begin failures++; $display("FAIL b2b_rsp1: got %h exp %h", g1, exp); end end
      checks++; if (viol != 0 || !seen) begin failures++; $display("FAIL b2b_ready: got early=%0d seen=%b exp early=0 seen=1", viol, seen); end
      wait_rsp(100, ok, got);
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_rsp2: got none exp %h", exp_q[0]); end
      else begin exp = exp_q.pop_front(); if (got !== exp) begin failures++; $display("FAIL b2b_rsp2: got %h exp %h", got, exp); end end
      rec_stop();
      for (int i = 0; i < rec_n; i++) if (!snap[i].nl) begin nl_cnt++; if (nl_cnt == 1) a1 = i; else a2 = i; end
      for (int i = a1 + 1; i < a2; i++) if (snap[i].ne) gap_idle = 1'b1;
      checks++; if (nl_cnt != 2 || !gap_idle) begin failures++; $display("FAIL b2b_addr_phases: got n=%0d gap=%b exp n=2 gap=1", nl_cnt, gap_idle); end
      checks++; if ({snap[a1].nbl, snap[a1].a, snap[a2].a} !== {2'b01, 12'h0AA, 12'h0BB}) begin failures++;
         $display("FAIL b2b_addr_fields: got %h exp %h", {snap[a1].nbl, snap[a1].a, snap[a2].a}, {2'b01, 12'h0AA, 12'h0BB}); end
   endtask

   task automatic test_reset_mid_access();
      bit ok, hit = 1'b0; int rv_cnt = 0;
      send(1'b1, 12'h555, 16'hC3C3, 2'b11, ok);
      for (int i = 0; i < 50; i++) begin
         if (dbg_state == ST_LAT) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({hit, FMC_NE, FMC_NWE, FMC_D_T, req_ready} !== {3'b111, 16'hFFFF, 1'b0}) begin failures++;
         $display("FAIL rst_mid_bus: got %h exp %h", {hit, FMC_NE, FMC_NWE, FMC_D_T, req_ready}, {3'b111, 16'hFFFF, 1'b0}); end
      repeat (4) begin @(negedge clk); if (rsp_valid) rv_cnt++; end
      rst_n = 1'b1;
      repeat (10) begin @(negedge clk); if (rsp_valid) rv_cnt++; end
      checks++; if (rv_cnt != 0) begin failures++; $display("FAIL rst_mid_rsp: got %0d pulses exp 0", rv_cnt); end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_addr = '0; req_wdata = '0; req_be = '0;
      test_reset();
      test_write();
      test_read(0, 16'hA5A5, "rd");
      test_read(3, 16'h3C5A, "rd_wait");
      test_timeout();
      test_zero_be();
      test_back_to_back();
      test_reset_mid_access();
      test_read(0, 16'h1111, "rd_after_rst");
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d left exp 0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fmc_mst_if.md
Name: fmc_mst_if

Overview:
- Host-side FMC master for synchronous PSRAM-mode FMC buses: the initiator end of the same bus our FMC slave interface responds to.
- Converts single-beat read/write requests from an internal valid/ready port into FMC bus cycles.
- Generates FMC_CLK, honours FMC_NWAIT wait states and returns read data.
- Used as an MCU emulator in loopback benches and to drive FMC-attached peripherals from the FPGA.

Parameters:
- C_ADDR_WIDTH, 12, FMC address bus width
- C_DATA_WIDTH, 16, FMC data bus width; multiple of 8
- C_CLK_DIV, 1, FMC_CLK half-period in clk cycles (1..15); FMC_CLK = clk/(2*C_CLK_DIV)
- C_DATLAT, 2, FMC_CLK cycles between address phase and first data phase (0..15)
- C_WAIT_TIMEOUT, 64, max consecutive FMC_CLK cycles with FMC_NWAIT low before abort

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_write  in  1  1=write, 0=read
- req_addr  in  C_ADDR_WIDTH  address
- req_wdata  in  C_DATA_WIDTH  write data
- req_be  in  C_DATA_WIDTH/8  byte enables, active-high
- rsp_valid  out  1  one-clk pulse, access finished
- rsp_rdata  out  C_DATA_WIDTH  read data; 0 for writes
- rsp_err  out  1  wait timeout, qualified by rsp_valid
- FMC_CLK  out  1  bus clock
- FMC_A  out  C_ADDR_WIDTH  address
- FMC_D_I  in  C_DATA_WIDTH  data from pad
- FMC_D_O  out  C_DATA_WIDTH  data to pad
- FMC_D_T  out  C_DATA_WIDTH  tristate, 1=high-Z
- FMC_NBL  out  C_DATA_WIDTH/8  byte lane enables, active-low
- FMC_NE  out  1  chip enable, active-low
- FMC_NL  out  1  address valid, active-low
- FMC_NOE  out  1  output enable, active-low
- FMC_NWE  out  1  write enable, active-low
- FMC_NWAIT  in  1  wait, active-low

Behaviour:
- One clock domain (clk); rst_n asynchronous active-low; FMC_CLK is a registered output, never a clock inside this block.
- Reset values:
  - FMC_CLK=0, FMC_NE/NL/NOE/NWE=1, FMC_NBL=all 1, FMC_D_T=all 1, FMC_D_O=0, FMC_A=0
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0
  - FSM=IDLE
- FMC_CLK runs free after reset: toggles every C_CLK_DIV clk cycles.
- fall_tick: the clk cycle in which FMC_CLK goes 1->0. rise_tick: the clk cycle in which FMC_CLK goes 0->1.
- All FMC outputs change only on fall_tick. FMC_D_I and FMC_NWAIT are sampled only on rise_tick, so the slave sees stable signals at its rising edge.
- req_ready=1 only in IDLE. Accepted request fields are registered; inputs are don't-care afterwards.
- FSM states (advance on fall_tick unless noted):
  - IDLE: on accepted request -> ADDR at next fall_tick.
  - ADDR, one FMC cycle: NE=0, NL=0, FMC_A=addr. NWE=0 if write. NOE=1. NBL=~be.
    - -> LAT if C_DATLAT>0, else DATA.
  - LAT: NL=1; hold NE, NWE, NBL. Count C_DATLAT FMC cycles -> DATA.
  - DATA, write: D_O=wdata, D_T=all 0.
  - DATA, read: NOE=0, D_T stays all 1.
  - DATA exit: leave DATA at the fall_tick after a rise_tick that sampled FMC_NWAIT=1.
    - Read data is captured on that rise_tick.
    - Each rise_tick that samples NWAIT=0 adds a wait cycle and increments wcnt.
    - wcnt reaching C_WAIT_TIMEOUT -> END with err=1.
  - END, one FMC cycle turnaround: NE, NOE, NWE, NL=1; NBL=all 1; D_T=all 1.
    - rsp_valid pulses one clk on END entry, with rdata and err.
    - -> IDLE. req_ready rises on the following clk.
- Latency, NWAIT always high, C_CLK_DIV=1, C_DATLAT=2: ADDR 1 + LAT 2 + DATA 1 + END 1 = 5 FMC cycles. The next request cannot start ADDR earlier than the fall_tick after END.
- Timeout: rsp_rdata=0, rsp_err=1. The bus is released normally through END.
- rsp_err=0 on every successful access.
- A request presented while busy is not accepted (ready=0); no queueing.
- FMC_NWAIT is ignored outside DATA.
- rst_n asserted mid-access: all outputs return to reset values immediately (asynchronous), with no rsp_valid.
- req_be=0 on a write: the cycle is still performed with NBL=all 1.

Decomposition:
- Shared package fmc_pkg: FSM state enum (IDLE, ADDR, LAT, DATA, END), FMC idle-level constants, tristate constants.
- Sub-module fmc_mst_clkgen: divider counter producing FMC_CLK, fall_tick, rise_tick.

Test Plan:
- Write addr 0x123, data 0xBEEF, be=2'b11, NWAIT=1 -> FMC_A=0x123 with NL=0 for one FMC cycle; D_O=0xBEEF with D_T=0 and NWE=0 in the DATA cycle; rsp_valid with err=0.
- Read addr 0x456, slave drives 0xA5A5 in DATA -> NOE=0 only in DATA; rsp_rdata=0xA5A5; total 5 FMC cycles.
- Read with NWAIT held low for 3 rise_ticks in DATA -> DATA lasts 4 FMC cycles; data captured after NWAIT=1; err=0.
- NWAIT stuck low, C_WAIT_TIMEOUT=64 -> after 64 wait cycles rsp_err=1, rsp_rdata=0; NE=1 and D_T=all 1 in END.
- Write be=2'b10 then back-to-back read with req_valid held high -> NBL=2'b01 on write; second ADDR starts only after END; req_ready low throughout.
- rst_n low during LAT of a write -> NE=1 and D_T=all 1 immediately; no rsp_valid; next request after release completes normally.
